// File: rtl/noc_edge_pkg.sv
// Shared constants and types for the mesh edge receive path.
// Optional idle timeout: define MESH_EDGE_RX_TIMEOUT_EN.
package noc_edge_pkg;

  localparam int FLIT_W = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_PKT_NIBBLES = 4;

  typedef enum logic {
    COLLECT,
    HOLD
  } asm_state_t;

endpackage

// File: rtl/mesh_edge_rx_if.sv
// Packet-side valid/ready bundle of the mesh edge receiver.
// master drives the packet, slave consumes it.
interface mesh_edge_rx_if
  import noc_edge_pkg::*;
#(
  parameter int PKT_NIBBLES = DEF_PKT_NIBBLES
);

  logic [FLIT_W*PKT_NIBBLES-1:0] pkt_data;
  logic                          pkt_valid;
  logic                          pkt_ready;

  modport master (
    output pkt_data,
    output pkt_valid,
    input  pkt_ready
  );

  modport slave (
    input  pkt_data,
    input  pkt_valid,
    output pkt_ready
  );

endinterface

// File: rtl/edge_rx_fifo.sv
// Flit FIFO for the mesh edge receiver: storage, pointers,
// occupancy, full/empty decode and sticky overflow flag.
module edge_rx_fifo
  import noc_edge_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FLIT_W-1:0]        wdata,
  input  logic                     wr,
  input  logic                     rd,
  output logic [FLIT_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;
  logic              wr_ok;
  logic              rd_ok;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;
  assign rdata = mem[rptr];
  assign level = count;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

  // Overflow looks at the registered full, so a same-cycle pop
  // does not rescue the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      if (wr & full) overflow <= 1'b1;
      unique case (1'b1)
        (wr_ok & ~rd_ok): count <= count + 1'b1;
        (rd_ok & ~wr_ok): count <= count - 1'b1;
        default:          count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_edge_rx.sv
// Mesh edge receive endpoint: flit FIFO plus packet assembler.
// Optional idle timeout: define MESH_EDGE_RX_TIMEOUT_EN.
module mesh_edge_rx
  import noc_edge_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int PKT_NIBBLES = DEF_PKT_NIBBLES,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FLIT_W-1:0]      link_in,
  input  logic                   link_w,
  output logic                   link_full,
  mesh_edge_rx_if.master         pkt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow_err,
  output logic                   timeout_err
);

  localparam int PW = FLIT_W * PKT_NIBBLES;
  localparam int NW = $clog2(PKT_NIBBLES);
  localparam logic [NW-1:0] LAST = NW'(PKT_NIBBLES - 1);

  if (TIMEOUT < 1 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2)
    begin : g_bad_param
    $error("mesh_edge_rx: bad DEPTH or TIMEOUT");
  end

  asm_state_t        state;
  logic [NW-1:0]     nib_cnt;
  logic [PW-1:0]     shreg;
  logic              valid;
  logic [FLIT_W-1:0] rdata;
  logic              empty;
  logic              pop;
  logic              tmo_fire;

  assign pop           = (state == COLLECT) & ~empty;
  assign pkt.pkt_data  = shreg;
  assign pkt.pkt_valid = valid;

  edge_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wdata    (link_in),
    .wr       (link_w),
    .rd       (pop),
    .rdata    (rdata),
    .full     (link_full),
    .empty    (empty),
    .level    (fifo_level),
    .overflow (overflow_err)
  );

`ifdef MESH_EDGE_RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] idle_cnt;
  logic          waiting;

  assign waiting  = (state == COLLECT) & (nib_cnt != '0) & empty;
  assign tmo_fire = waiting & (idle_cnt == IW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_fire;
      if (!waiting || tmo_fire) idle_cnt <= '0;
      else                      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // First popped flit travels up to the MSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      nib_cnt <= '0;
      shreg   <= '0;
      valid   <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (pop) begin
            shreg <= {shreg[PW-FLIT_W-1:0], rdata};
            if (nib_cnt == LAST) begin
              nib_cnt <= '0;
              state   <= HOLD;
              valid   <= 1'b1;
            end else begin
              nib_cnt <= nib_cnt + 1'b1;
            end
          end else if (tmo_fire) begin
            nib_cnt <= '0;
          end
        end
        HOLD: begin
          if (pkt.pkt_ready) begin
            state <= COLLECT;
            valid <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_edge_rx.sv
// Self-checking bench for mesh_edge_rx: vector table, corner
// sequences and a queue-based reference for random traffic.
module tb_mesh_edge_rx;
  import noc_edge_pkg::*;

  localparam int DEPTH = 4;
  localparam int PN    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] link_in;
  logic       link_w;
  logic       link_full;
  logic [2:0] fifo_level;
  logic       overflow_err;
  logic       timeout_err;

  mesh_edge_rx_if #(.PKT_NIBBLES(PN)) pkt ();

  mesh_edge_rx #(
    .DEPTH       (DEPTH),
    .PKT_NIBBLES (PN),
    .TIMEOUT     (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .link_in      (link_in),
    .link_w       (link_w),
    .link_full    (link_full),
    .pkt          (pkt),
    .fifo_level   (fifo_level),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         rst;
    bit         w;
    logic [3:0] f;
    bit         rdy;
    int         lvl;
    bit         full;
    bit         vld;
    logic [15:0] data;
    bit         ovf;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit rst, bit w, logic [3:0] f, bit rdy,
                              int lvl, bit full, bit vld,
                              logic [15:0] data, bit ovf);
    vec_t v;
    v.rst = rst; v.w = w; v.f = f; v.rdy = rdy; v.lvl = lvl;
    v.full = full; v.vld = vld; v.data = data; v.ovf = ovf;
    return v;
  endfunction

  function automatic logic [15:0] pack(input logic [3:0] q[$]);
    logic [15:0] r = '0;
    foreach (q[i]) r = {r[11:0], q[i]};
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    link_w = 1'b0;
    pkt.pkt_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic put(input logic [3:0] f);
    link_w = 1'b1;
    link_in = f;
    @(negedge clk);
    link_w = 1'b0;
  endtask

  task automatic wait_pkt(input string name, input logic [15:0] exp);
    for (int i = 0; i < 30; i++) begin
      if (pkt.pkt_valid === 1'b1) break;
      @(negedge clk);
    end
    check({name, "_valid"}, pkt.pkt_valid, 1);
    check({name, "_data"}, pkt.pkt_data, exp);
    pkt.pkt_ready = 1'b1;
    @(negedge clk);
    pkt.pkt_ready = 1'b0;
  endtask

  // Reference state for random traffic
  logic [3:0]  mq[$];
  logic [3:0]  mcol[$];
  bit          mhold;
  logic [15:0] mheld;
  bit          movf;

  initial begin
    int tpulse;
    int prev_lvl;
    int d;
    bit w, rdy, h0, fullm, popm;
    logic [3:0] f;

    rst_n = 1'b0;
    link_w = 1'b1;
    link_in = 4'h5;
    pkt.pkt_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_full", link_full, 0);
    check("rst_valid", pkt.pkt_valid, 0);
    check("rst_data", pkt.pkt_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_tmo", timeout_err, 0);
    link_w = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_full", link_full, 0);
    check("post_rst_level", fifo_level, 0);

    // Back-to-back ABCD, then backpressure with overflow
    vt.push_back(mk(1, 1, 4'hA, 1, 1, 0, 0, 16'h0, 0));
    vt.push_back(mk(0, 1, 4'hB, 1, 1, 0, 0, 16'h0, 0));
    vt.push_back(mk(0, 1, 4'hC, 1, 1, 0, 0, 16'h0, 0));
    vt.push_back(mk(0, 1, 4'hD, 1, 1, 0, 0, 16'h0, 0));
    vt.push_back(mk(0, 0, 4'h0, 1, 0, 0, 1, 16'hABCD, 0));
    vt.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 16'h0, 0));
    vt.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 16'h0, 0));
    vt.push_back(mk(1, 1, 4'h1, 0, 1, 0, 0, 16'h0, 0));
    vt.push_back(mk(0, 1, 4'h2, 0, 1, 0, 0, 16'h0, 0));
    vt.push_back(mk(0, 1, 4'h3, 0, 1, 0, 0, 16'h0, 0));
    vt.push_back(mk(0, 1, 4'h4, 0, 1, 0, 0, 16'h0, 0));
    vt.push_back(mk(0, 1, 4'h5, 0, 1, 0, 1, 16'h1234, 0));
    vt.push_back(mk(0, 1, 4'h6, 0, 2, 0, 1, 16'h1234, 0));
    vt.push_back(mk(0, 1, 4'h7, 0, 3, 0, 1, 16'h1234, 0));
    vt.push_back(mk(0, 1, 4'h8, 0, 4, 1, 1, 16'h1234, 0));
    vt.push_back(mk(0, 1, 4'h9, 0, 4, 1, 1, 16'h1234, 1));
    vt.push_back(mk(0, 0, 4'h0, 1, 4, 1, 0, 16'h0, 1));
    vt.push_back(mk(0, 0, 4'h0, 1, 3, 0, 0, 16'h0, 1));
    vt.push_back(mk(0, 0, 4'h0, 1, 2, 0, 0, 16'h0, 1));
    vt.push_back(mk(0, 0, 4'h0, 1, 1, 0, 0, 16'h0, 1));
    vt.push_back(mk(0, 0, 4'h0, 1, 0, 0, 1, 16'h5678, 1));
    vt.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 16'h0, 1));

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      link_w = vt[i].w;
      link_in = vt[i].f;
      pkt.pkt_ready = vt[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_level", i), fifo_level, vt[i].lvl);
      check($sformatf("vec%0d_full", i), link_full, vt[i].full);
      check($sformatf("vec%0d_valid", i), pkt.pkt_valid, vt[i].vld);
      check($sformatf("vec%0d_ovf", i), overflow_err, vt[i].ovf);
      if (vt[i].vld)
        check($sformatf("vec%0d_data", i), pkt.pkt_data, vt[i].data);
    end
    link_w = 1'b0;
    pkt.pkt_ready = 1'b0;

    // Partial packet with an idle gap
    do_reset();
    put(4'h7);
    put(4'h7);
    tpulse = 0;
    repeat (20) begin
      @(negedge clk);
      if (timeout_err === 1'b1) tpulse++;
    end
`ifdef MESH_EDGE_RX_TIMEOUT_EN
    check("tmo_pulses", tpulse, 1);
    put(4'h1); put(4'h2); put(4'h3); put(4'h4);
    wait_pkt("tmo_after", 16'h1234);
`else
    check("tmo_pulses", tpulse, 0);
    check("partial_level", fifo_level, 0);
    check("partial_valid", pkt.pkt_valid, 0);
    put(4'h1); put(4'h2);
    wait_pkt("partial_done", 16'h7712);
`endif

    // Reset in the middle of a packet, with a write in flight
    do_reset();
    put(4'h3); put(4'h6); put(4'h9);
    link_w = 1'b1;
    link_in = 4'hC;
    #2 rst_n = 1'b0;
    #1 check("midrst_level", fifo_level, 0);
    check("midrst_valid", pkt.pkt_valid, 0);
    @(negedge clk);
    link_w = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_level2", fifo_level, 0);
    put(4'hE); put(4'hF); put(4'h0); put(4'h1);
    wait_pkt("midrst_pkt", 16'hEF01);

    // Random traffic against the queue model
    do_reset();
    @(negedge clk);
    mq.delete(); mcol.delete();
    mhold = 0; mheld = '0; movf = 0;
    prev_lvl = 0;
    for (int c = 0; c < 600; c++) begin
      w = (c < 300) ? (($urandom % 4) != 0) : 1'b1;
      rdy = (c < 300) ? (($urandom % 3) != 0) : 1'b1;
      f = 4'($urandom);
      link_w = w;
      link_in = f;
      pkt.pkt_ready = rdy;
      h0 = mhold;
      fullm = (mq.size() == DEPTH);
      popm = !h0 && (mq.size() > 0);
      if (h0 && rdy) mhold = 0;
      if (popm) begin
        mcol.push_back(mq.pop_front());
        if (mcol.size() == PN) begin
          mheld = pack(mcol);
          mcol.delete();
          mhold = 1;
        end
      end
      if (w) begin
        if (!fullm) mq.push_back(f);
        else movf = 1;
      end
      @(negedge clk);
      check("rnd_level", fifo_level, mq.size());
      check("rnd_full", link_full, mq.size() == DEPTH);
      check("rnd_valid", pkt.pkt_valid, mhold);
      check("rnd_ovf", overflow_err, movf);
      if (mhold) check("rnd_data", pkt.pkt_data, mheld);
      d = int'(fifo_level) - prev_lvl;
      check("rnd_step", (d <= 1 && d >= -1), 1);
      prev_lvl = int'(fifo_level);
    end
    link_w = 1'b0;
    pkt.pkt_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
